// File: rtl/decoder_rr_arbiter32_if.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_rr_arbiter32_if
//  Purpose  : Request/grant bundle between requesting agents and the arbiter.
//  Revision : 1.0
// ============================================================================
interface decoder_rr_arbiter32_if;
    logic [31:0] req;
    logic        done;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/decoder_rr_arbiter32.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_rr_arbiter32
//  Purpose  : 32-way round-robin arbiter with registered winner index and
//             one-hot decoded grant, hold timeout and break-before-make gap.
//  Revision : 1.0
// ============================================================================
module decoder_rr_arbiter32 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decoder_rr_arbiter32_if.slave  arb_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LIMIT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q;
    logic [4:0]       ptr_q;
    logic [4:0]       gnt_idx_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             timeout_q;

    logic [63:0]      w_req_dbl;
    logic [31:0]      w_req_rot;
    logic [4:0]       w_win_off;
    logic [4:0]       w_winner;
    logic             w_rel_done;
    logic             w_rel_drop;
    logic             w_limit;
    logic             w_release;

    // Rotate so the current pointer lands at bit 0; the lowest set bit is the winner offset.
    assign w_req_dbl = {arb_if.req, arb_if.req} >> ptr_q;
    assign w_req_rot = w_req_dbl[31:0];

    always_comb begin
        w_win_off = '0;
        for (int i = 31; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_win_off = 5'(i);
            end
        end
    end

    assign w_winner   = ptr_q + w_win_off;
    assign w_rel_done = arb_if.done;
    assign w_rel_drop = ~arb_if.req[gnt_idx_q];
    assign w_limit    = (MAX_HOLD != 0) && (hold_cnt_q == c_LIMIT);
    assign w_release  = w_rel_done | w_rel_drop | w_limit;
    assign hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_if.req != '0) begin
                        gnt_idx_q  <= w_winner;
                        hold_cnt_q <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    hold_cnt_q <= hold_cnt_d;
                    if (w_release) begin
                        ptr_q     <= gnt_idx_q + 5'd1;
                        // A release by done or withdrawal masks a coincident limit hit.
                        timeout_q <= w_limit & ~w_rel_done & ~w_rel_drop;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign arb_if.gnt       = (state_q == BUSY) ? (32'd1 << gnt_idx_q) : '0;
    assign arb_if.gnt_valid = (state_q == BUSY);
    assign arb_if.gnt_idx   = gnt_idx_q;
    assign arb_if.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_rr_arbiter32
//  Purpose  : Self-checking bench: vector table, corner sequences, random run
//             against a transaction-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_decoder_rr_arbiter32;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst_n;

    decoder_rr_arbiter32_if ifc ();

    decoder_rr_arbiter32 #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the resource, for how many cycles, and what comes next.
    bit         m_busy;
    bit         m_gap;
    logic [4:0] m_idx;
    int         m_ptr;
    int         m_held;
    bit         m_to;

    function automatic int pick(logic [31:0] r, int p);
        for (int k = 0; k < 32; k++) begin
            if (r[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gap = 0; m_idx = '0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    task automatic model_step();
        if (m_busy) begin
            bit rel_d, rel_w, rel_t;
            rel_d = ifc.done;
            rel_w = !ifc.req[m_idx];
            rel_t = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (rel_d || rel_w || rel_t) begin
                m_busy = 0;
                m_gap  = 1;
                m_ptr  = (int'(m_idx) + 1) % 32;
                m_to   = rel_t && !rel_d && !rel_w;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
            m_to  = 0;
        end else if (ifc.req != '0) begin
            m_idx  = 5'(pick(ifc.req, m_ptr));
            m_busy = 1;
            m_held = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {25'd0, ifc.gnt, ifc.gnt_idx, ifc.gnt_valid, ifc.timeout};
    endfunction

    function automatic logic [63:0] mk_vec(logic [31:0] g, logic [4:0] i, logic v, logic t);
        return {25'd0, g, i, v, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", dut_vec(),
            mk_vec(m_busy ? (32'd1 << m_idx) : 32'd0, m_idx, m_busy, m_to));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ifc.req  = '0;
        ifc.done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [31:0] req;
        logic        done;
        logic [31:0] gnt;
        logic [4:0]  idx;
        logic        valid;
        logic        to;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0100, 1'b0, 32'h0000_0100, 5'd8,  1'b1, 1'b0};
        vecs[1]  = '{32'h0000_0100, 1'b0, 32'h0000_0100, 5'd8,  1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0100, 1'b0, 32'h0000_0100, 5'd8,  1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0100, 1'b1, 32'h0000_0000, 5'd8,  1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0100, 1'b0, 32'h0000_0000, 5'd8,  1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0100, 1'b0, 32'h0000_0100, 5'd8,  1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0001, 1'b1, 32'h0000_0000, 5'd8,  1'b0, 1'b0};
        vecs[7]  = '{32'h8000_0001, 1'b0, 32'h0000_0000, 5'd8,  1'b0, 1'b0};
        vecs[8]  = '{32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0};
        vecs[9]  = '{32'h8000_0001, 1'b1, 32'h0000_0000, 5'd31, 1'b0, 1'b0};
        vecs[10] = '{32'h8000_0001, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b0};
        vecs[11] = '{32'h8000_0001, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0};
        vecs[12] = '{32'h8000_0001, 1'b1, 32'h0000_0000, 5'd0,  1'b0, 1'b0};
        vecs[13] = '{32'h8000_0001, 1'b0, 32'h0000_0000, 5'd0,  1'b0, 1'b0};
        vecs[14] = '{32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0};
        vecs[15] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b0};
        vecs[16] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b0};
        vecs[17] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b0, 1'b0};

        do_reset();
        chk("reset_state", dut_vec(), mk_vec(32'd0, 5'd0, 1'b0, 1'b0));

        // Single request, repeat grant, fairness skip and withdrawal.
        for (int i = 0; i < 18; i++) begin
            ifc.req  = vecs[i].req;
            ifc.done = vecs[i].done;
            tick();
            chk($sformatf("vec%0d", i), dut_vec(),
                mk_vec(vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].to));
        end

        // Rotation with all requesters active, including the 31 -> 0 wrap.
        do_reset();
        ifc.req = 32'hFFFF_FFFF;
        tick();
        for (int k = 0; k < 33; k++) begin
            chk("rot_idx", {59'd0, ifc.gnt_idx}, 64'(k % 32));
            chk("rot_gnt", {32'd0, ifc.gnt}, {32'd0, 32'd1 << (k % 32)});
            ifc.done = 1'b1;
            tick();
            chk("rot_gap", {32'd0, ifc.gnt}, 64'd0);
            ifc.done = 1'b0;
            tick();
            tick();
        end

        // Timeout: grantee never releases, pointer moves past it.
        do_reset();
        ifc.req = 32'h0000_0030;
        begin
            int busy_cycles;
            busy_cycles = 0;
            tick();
            for (int c = 0; c < 40 && ifc.gnt_valid; c++) begin
                busy_cycles++;
                tick();
            end
            chk("to_len", 64'(busy_cycles), 64'(MAX_HOLD));
            chk("to_pulse", {62'd0, ifc.timeout, ifc.gnt_valid}, 64'b10);
            tick();
            chk("to_clear", {63'd0, ifc.timeout}, 64'd0);
            tick();
            chk("to_next", {59'd0, ifc.gnt_idx}, 64'd5);
        end

        // Done coincides with the hold limit on BUSY cycle 16.
        do_reset();
        ifc.req = 32'h0000_0010;
        tick();
        repeat (MAX_HOLD - 1) tick();
        chk("col_busy16", {63'd0, ifc.gnt_valid}, 64'd1);
        ifc.done = 1'b1;
        tick();
        ifc.done = 1'b0;
        chk("col_no_to", {62'd0, ifc.timeout, ifc.gnt_valid}, 64'd0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        ifc.req = 32'h0000_0400;
        tick();
        chk("rst_pre", {32'd0, ifc.gnt}, 64'h400);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {30'd0, ifc.gnt, ifc.gnt_valid, ifc.timeout}, 64'd0);
        model_reset();
        ifc.req = 32'h0000_0408;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_first", {32'd0, ifc.gnt}, 64'h8);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       ifc.req = '0;
                    1:       ifc.req = 32'd1 << $urandom_range(0, 31);
                    2:       ifc.req = $urandom;
                    default: ifc.req = $urandom & $urandom & $urandom;
                endcase
            end
            ifc.done = ($urandom_range(0, 9) == 0);
            tick();
            chk("onehot", 64'(($countones(ifc.gnt) <= 1) && (ifc.gnt_valid || ifc.gnt == '0)), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
